mac_v5: RTL and testbench
=========================

// Module: mac_v5
// PURPOSE
//   Unsigned 4x4 multiply-accumulate over fixed-length frames of input-feature-map (IFM) pixel pairs.
//   Each valid cycle adds in1_IFM*in2_IFM to a running sum.
//   After DEPTH valid samples, the block outputs the frame sum with a one-cycle out_valid strobe.
//   It then restarts from zero.
//   Sits in the convolution datapath between the IFM/weight feeders and the output buffer.
// PARAMETERS
//   IN_W   4   operand width (unsigned)
//   OUT_W  10  accumulator/output width
//   DEPTH  9   valid samples per frame (3x3 window); legal range 1..2^OUT_W-1
// PORTS
//   clk        in   1      single clock, all state updates on rising edge
//   rst_n      in   1      reset, asynchronous, ACTIVE-HIGH (port keeps codebase name; 1 = reset)
//   in1_IFM    in   IN_W   operand A, unsigned
//   in2_IFM    in   IN_W   operand B, unsigned
//   in_valid   in   1      operands valid this cycle
//   out        out  OUT_W  frame sum, registered, held between frames
//   out_valid  out  1      one-cycle strobe: out carries a new frame sum
// BEHAVIOUR
// - Reset (rst_n=1, any time, async): acc=0, cnt=0, out=0, out_valid=0; held while rst_n=1.
// - Product: prod = in1_IFM*in2_IFM, 2*IN_W bits, zero-extended to OUT_W before add.
// - Sample accepted on rising edge with in_valid=1; in_valid=0 cycles are gaps.
// - During a gap, acc and cnt hold, out holds, out_valid=0; no timeout.
// - Accepted sample with cnt<DEPTH-1: acc<=acc+prod, cnt<=cnt+1, out_valid<=0.
// - Accepted sample with cnt==DEPTH-1 (last of frame):
//   - out<=acc+prod and out_valid<=1.
//   - acc<=0, cnt<=0.
//   - Sum visible the cycle after the last sample (latency 1).
// - out_valid is high exactly one cycle per frame.
// - Back-to-back frames need no idle cycle: a sample on the edge after the last one starts the next frame.
// - DEPTH=1: every accepted sample produces out=prod and out_valid=1.
// - No input ready/backpressure; every in_valid=1 cycle is consumed.
// - Operands are don't-care when in_valid=0.
// - Reset mid-frame discards the partial sum; the next accepted sample is sample 1 of a new frame.
// - Overflow (sum > 2^OUT_W-1) is handled per CONFIGURATION; no overflow flag port.
// CONFIGURATION
//   MAC_SAT_EN defined:
//   - Accumulation saturates: acc+prod clamps to 2^OUT_W-1 (1023), including the final add.
//   - A saturated accumulator stays at 1023 until the frame ends.
//   MAC_SAT_EN undefined:
//   - Accumulation wraps modulo 2^OUT_W (plain OUT_W-bit add).
//   Both builds: identical ports and timing.
// TESTING (DEPTH=9 unless noted)
// 1. Reset: rst_n=1 mid-cycle asynchronously -> out=0, out_valid=0 immediately; stays so for 10 cycles after release with in_valid=0.
// 2. Basic frame: (1,2),(5,4), then seven (0,0), in_valid=1 continuously.
//    -> out=22, one-cycle out_valid after the 9th sample.
// 3. Gaps: same 9 samples with in_valid=0 between each and garbage operands during gaps -> out=22 once; no early strobe.
// 4. Overflow: nine samples of (15,15); true sum is 2025.
//    -> out=1023 with MAC_SAT_EN; out=1001 without.
// 5. Back-to-back: frame of nine (3,3) then immediately nine (2,1).
//    -> out=81 then out=18, strobes exactly 9 cycles apart.
// 6. Reset mid-frame: 4 samples (15,15), assert rst_n, release, then 9 samples (1,1).
//    -> out=9 (partial sum discarded); also DEPTH=1 build: (7,8) -> out=56 every valid cycle.

Source files
------------

// File: rtl/mac_v5.sv
// Unsigned IN_W x IN_W multiply-accumulate over DEPTH-sample frames; strobes out_valid with each frame sum.
// Optional build macro MAC_SAT_EN: saturate the accumulator at 2^OUT_W-1 instead of wrapping.
module mac_v5 #(
  parameter int unsigned IN_W  = 4,
  parameter int unsigned OUT_W = 10,
  parameter int unsigned DEPTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  in1_IFM,
  input  logic [IN_W-1:0]  in2_IFM,
  input  logic             in_valid,
  output logic [OUT_W-1:0] out,
  output logic             out_valid
);

  localparam int unsigned PROD_W = 2 * IN_W;
  localparam int unsigned CNT_W  = OUT_W;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

  logic [PROD_W-1:0] prod;
  logic [OUT_W-1:0]  acc;
  logic [OUT_W-1:0]  sum;
  logic [CNT_W-1:0]  cnt;

  assign prod = PROD_W'(in1_IFM) * PROD_W'(in2_IFM);

`ifdef MAC_SAT_EN
  localparam int unsigned SUM_W = ((PROD_W > OUT_W) ? PROD_W : OUT_W) + 1;
  localparam logic [OUT_W-1:0] MAX_SUM = '1;

  logic [SUM_W-1:0] sum_wide;

  // Clamp at full scale; once there, acc stays pinned until the frame ends.
  always_comb begin
    sum_wide = SUM_W'(acc) + SUM_W'(prod);
    sum      = (sum_wide > SUM_W'(MAX_SUM)) ? MAX_SUM : OUT_W'(sum_wide);
  end
`else
  // Modulo-2^OUT_W accumulation.
  assign sum = acc + OUT_W'(prod);
`endif

  // Frame counter, accumulator and registered outputs. Reset is active-high despite the port name.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (in_valid) begin
        if (cnt == LAST) begin
          out       <= sum;
          out_valid <= 1'b1;
          acc       <= '0;
          cnt       <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_v5.sv
// Directed bench for mac_v5: a DEPTH=9 instance for frame behaviour and a DEPTH=1 instance sharing its inputs.
module tb_mac_v5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] a;
  logic [3:0] b;
  logic       v;
  logic [9:0] out9;
  logic       ov9;
  logic [9:0] out1;
  logic       ov1;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int strobe_cyc [$];

  always #5 clk = ~clk;

  mac_v5 #(.IN_W(4), .OUT_W(10), .DEPTH(9)) dut (
    .clk(clk), .rst_n(rst_n), .in1_IFM(a), .in2_IFM(b),
    .in_valid(v), .out(out9), .out_valid(ov9)
  );

  mac_v5 #(.IN_W(4), .OUT_W(10), .DEPTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in1_IFM(a), .in2_IFM(b),
    .in_valid(v), .out(out1), .out_valid(ov1)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Apply operands, clock once, then sample 1 ns after the edge.
  task automatic send(input int x, input int y, input logic val);
    a = 4'(x);
    b = 4'(y);
    v = val;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int exp_ovf;
    rst_n = 1'b1;
    a = '0;
    b = '0;
    v = 1'b0;

    // Test 1: reset, then 10 idle cycles after release
    #3;
    check("rst_out", int'(out9), 0);
    check("rst_ov", int'(ov9), 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      send(0, 0, 1'b0);
      check("idle_ov", int'(ov9), 0);
      check("idle_out", int'(out9), 0);
    end

    // Test 2: basic frame, continuous valid
    for (int i = 0; i < 9; i++) begin
      send((i == 0) ? 1 : (i == 1) ? 5 : 0, (i == 0) ? 2 : (i == 1) ? 4 : 0, 1'b1);
      check("basic_ov", int'(ov9), (i == 8) ? 1 : 0);
    end
    check("basic_out", int'(out9), 22);
    send(0, 0, 1'b0);
    check("basic_ov_drop", int'(ov9), 0);
    check("basic_hold", int'(out9), 22);

    // Test 3: same samples with gaps carrying garbage operands
    for (int i = 0; i < 9; i++) begin
      send((i == 0) ? 1 : (i == 1) ? 5 : 0, (i == 0) ? 2 : (i == 1) ? 4 : 0, 1'b1);
      check("gap_ov", int'(ov9), (i == 8) ? 1 : 0);
      if (i == 8) check("gap_out", int'(out9), 22);
      send(15, 13, 1'b0);
      check("gap_idle_ov", int'(ov9), 0);
    end
    check("gap_hold", int'(out9), 22);

    // Test 4: overflow
`ifdef MAC_SAT_EN
    exp_ovf = 1023;
`else
    exp_ovf = 1001;
`endif
    for (int i = 0; i < 9; i++) begin
      send(15, 15, 1'b1);
      check("ovf_ov", int'(ov9), (i == 8) ? 1 : 0);
    end
    check("ovf_out", int'(out9), exp_ovf);

    // Test 5: back-to-back frames
    strobe_cyc.delete();
    for (int i = 0; i < 18; i++) begin
      send((i < 9) ? 3 : 2, (i < 9) ? 3 : 1, 1'b1);
      if (ov9) strobe_cyc.push_back(cyc);
      check("b2b_ov", int'(ov9), (i == 8 || i == 17) ? 1 : 0);
      if (i == 8)  check("b2b_out1", int'(out9), 81);
      if (i == 17) check("b2b_out2", int'(out9), 18);
    end
    check("b2b_nstrobe", strobe_cyc.size(), 2);
    if (strobe_cyc.size() == 2)
      check("b2b_spacing", strobe_cyc[1] - strobe_cyc[0], 9);

    // Test 6: reset mid-frame, asserted between edges
    for (int i = 0; i < 4; i++) send(15, 15, 1'b1);
    check("mid_out_before", int'(out9), 18);
    #2;
    rst_n = 1'b1;
    #1;
    check("mid_async_out", int'(out9), 0);
    check("mid_async_ov", int'(ov9), 0);
    send(0, 0, 1'b0);
    rst_n = 1'b0;
    for (int i = 0; i < 9; i++) begin
      send(1, 1, 1'b1);
      check("mid_ov", int'(ov9), (i == 8) ? 1 : 0);
    end
    check("mid_out", int'(out9), 9);

    // DEPTH=1 instance: every valid sample is a frame
    for (int i = 0; i < 4; i++) begin
      send(7, 8, (i != 2));
      check("d1_ov", int'(ov1), (i != 2) ? 1 : 0);
      check("d1_out", int'(out1), 56);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
